// File: rtl/alu_pipe_if.sv
// Operand and result handshake bundle for alu_pipe.
// The slave modport is the ALU side. The master modport is the producer/consumer side.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_signed, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_signed, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_err, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with an iterative shift-add multiplier; the multiplier exists only with ALU_PIPE_MUL_EN.
// Latency: a result registers on the accept edge; a multiply result registers WIDTH edges after the accept edge.
// Backpressure: a held result blocks new accepts; a result can drain in the same cycle as an accept.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

    logic                    accept;
    logic                    is_mul;
    logic                    eq;
    logic                    lt;
    logic                    big;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_err;

    assign accept  = bus.in_valid && bus.in_ready;
    assign eq      = bus.in_a == bus.in_b;
    assign lt      = bus.in_signed ? ($signed(bus.in_a) < $signed(bus.in_b)) : (bus.in_a < bus.in_b);
    assign big     = bus.in_b >= WLIM;
    // Kept separate so the arithmetic shift is never evaluated in an unsigned context.
    assign sra_res = $signed(bus.in_a) >>> bus.in_b;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.in_op)
            4'b0000: alu_res = bus.in_a + bus.in_b;
            4'b0001: alu_res = bus.in_a - bus.in_b;
            4'b0010: alu_res = {{(WIDTH-1){1'b0}}, eq};
            4'b0011: alu_res = {{(WIDTH-1){1'b0}}, !eq};
            4'b0100: alu_res = {{(WIDTH-1){1'b0}}, lt};
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, lt || eq};
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, !(lt || eq)};
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, !lt};
            4'b1000: alu_res = bus.in_a ^ bus.in_b;
            4'b1001: alu_res = bus.in_a | bus.in_b;
            4'b1010: alu_res = bus.in_a & bus.in_b;
            4'b1011: alu_res = big ? '0 : (bus.in_a << bus.in_b);
            4'b1100: alu_res = big ? '0 : (bus.in_a >> bus.in_b);
            4'b1110: alu_res = big ? {WIDTH{bus.in_a[WIDTH-1]}} : sra_res;
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] prod_next;
    logic             mul_done;

    assign is_mul       = bus.in_op == 4'b1101;
    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign prod_next    = prod + (mplier[0] ? mcand : '0);
    assign mul_done     = (state == MUL) && (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state    <= MUL;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        mcand    <= bus.in_a;
                        mplier   <= bus.in_b;
                        prod     <= '0;
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle; bits above WIDTH fall off the top of mcand.
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_done) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign is_mul       = 1'b0;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign bus.busy     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_err    <= 1'b0;
        end else if (accept && !is_mul) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= alu_res;
            bus.out_zero   <= alu_res == '0;
            bus.out_err    <= alu_err;
`ifdef ALU_PIPE_MUL_EN
        end else if (mul_done) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= prod_next;
            bus.out_zero   <= prod_next == '0;
            bus.out_err    <= 1'b0;
`endif
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, handshaked successor to the combinational ALU.
- Width is parametrised; operands are accepted on a valid/ready input channel and results are returned on a valid/ready output channel.
- Adds signed compare/shift modes, a zero flag, an illegal-opcode error flag and an iterative shift-add multiplier.
- Sits between operand fetch and write-back in the datapath; back-pressure-safe.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  operand 1.
- in_b  input  WIDTH  operand 2 (shift amount for shifts).
- in_op  input  4  opcode.
- in_signed  input  1  1 = compares treat operands as two's complement.
- out_valid  output  1  result held on out_result.
- out_ready  input  1  consumer takes result this cycle.
- out_result  output  WIDTH  result.
- out_zero  output  1  out_result == 0.
- out_err  output  1  opcode was illegal.
- busy  output  1  multiply in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - out_valid, out_result, out_zero, out_err and busy all 0.
  - in_ready = 1 once rst deasserts.
- Accept occurs when in_valid && in_ready. Operands and opcode are captured at that edge; inputs are don't-care otherwise.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A result being drained and a new accept may occur in the same cycle; this gives full throughput for single-cycle ops.
- out_valid stays high and out_result/out_zero/out_err stay stable until out_ready is high. A transfer occurs when out_valid && out_ready.
- Opcodes:
  - 0000 add, 0001 sub. Both wrap modulo 2^WIDTH with no carry out.
  - 0010 eq, 0011 ne, 0100 lt, 0101 le, 0110 gt, 0111 ge. Result is the compare bit zero-extended to WIDTH. Signed compare when in_signed = 1, else unsigned.
  - 1000 xor, 1001 or, 1010 and.
  - 1011 sll, 1100 srl, 1110 sra. The shift amount is the full in_b value. Any amount >= WIDTH gives 0 for sll/srl and all-copies-of-sign-bit for sra.
  - 1101 mul: low WIDTH bits of the unsigned product; in_signed is ignored.
  - 1111: illegal.
- Illegal opcode: out_result = 0, out_err = 1, out_zero = 1, latency 1.
- Latency for all ops except mul: 1 cycle. out_valid rises on the edge after the accept.
- State machine IDLE / MUL:
  - IDLE -> MUL on accept of op 1101. busy = 1 and in_ready = 0 while in MUL.
  - In MUL: one shift-add step per cycle over WIDTH cycles, using an internal bit counter that counts 0..WIDTH-1.
  - MUL -> IDLE on the last step. out_valid rises on the same edge, so mul latency is WIDTH cycles from accept to out_valid.
- Entering MUL requires the output register to be free or draining, which is already guaranteed by in_ready.
- out_zero is computed from the registered result, never combinationally from the inputs.
- Reset mid-multiply aborts the operation. All outputs return to reset values and no partial result is emitted.
- Back-pressure: while out_valid = 1 and out_ready = 0, no new accept happens and the held result must not change.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: op 1101 behaves as the multiplier above, and the MUL state and counter are present.
- Undefined: no multiplier logic is generated and busy is tied 0. Op 1101 is treated as illegal: out_err = 1, result 0, latency 1.

Test Plan:
- Reset asserted asynchronously mid-cycle -> out_valid, out_result, out_err and busy go to 0 immediately; in_ready = 1 after release.
- add a = 0xFFFFFFFF, b = 0x00000001 -> out_result = 0x00000000, out_zero = 1, out_valid one cycle after accept. Back-to-back sub 5 - 7 accepted on the next cycle with out_ready = 1 -> 0xFFFFFFFE on the following cycle (no bubble).
- lt a = 0xFFFFFFFF, b = 0x00000001:
  - with in_signed = 0 -> 0x00000000.
  - with in_signed = 1 -> 0x00000001.
  - sra a = 0x80000000, b = 40 -> 0xFFFFFFFF.
  - srl with the same operands -> 0x00000000.
- mul a = 0x00010003, b = 0x00020005 (ALU_PIPE_MUL_EN defined) -> busy for 32 cycles, in_ready = 0 throughout, result 0x000B000F with out_valid at cycle 32 after accept. Without the macro -> out_err = 1, result 0 after 1 cycle.
- Back-pressure: out_ready held 0 for 5 cycles after an xor result 0xA5A5A5A5 while in_valid = 1 -> result stable, in_ready = 0, no second accept; out_ready = 1 -> transfer, and the next op is accepted the same cycle.
- Op 1111 with any operands -> out_err = 1, out_result = 0, out_zero = 1; the next legal op clears out_err.
